// File: rtl/wptr_ctrl.sv
// wptr_ctrl: write-side pointer controller for the dual-clock AXIS FIFO.
// Tracks the binary write pointer and the committed pointer. Only the
// committed pointer is published to the read domain, as a registered gray
// code. The gray read pointer is synchronised into wclk. Registered
// occupancy, full and almost_full are derived from that synchronised pointer.
// In packet mode, writes stay private until w_last commits them. w_drop
// rewinds the write pointer to the last commit point.
// SYNC_STAGES must be at least 2.

module wptr_ctrl #(
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PKT_MODE    = 0
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic                 w_last,
  input  logic                 w_drop,
  input  logic [PTR_WIDTH:0]   g_rptr_async,
  input  logic [PTR_WIDTH:0]   afull_thr,
  input  logic                 ovf_clr,
  output logic                 wr_ok,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   usedw,
  output logic                 overflow
);

  localparam int AW = PTR_WIDTH + 1;
  localparam logic [AW-1:0] DEPTH = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [AW-1:0] ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic          PKT   = (PKT_MODE != 0) ? 1'b1 : 1'b0;

  function automatic logic [AW-1:0] bin2gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b[AW-1] = g[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW-1:0] r_b_wptr;
  logic [AW-1:0] r_b_cptr;
  logic [AW-1:0] r_g_wptr;
  logic [AW-1:0] r_sync [SYNC_STAGES];
  logic [AW-1:0] r_b_rptr_sync;
  logic          r_full;
  logic          r_almost_full;
  logic [AW-1:0] r_usedw;
  logic          r_overflow;

  logic          w_drop_eff;
  logic          w_acc;
  logic          w_ovf_att;
  logic [AW-1:0] w_wptr_inc;
  logic [AW-1:0] w_b_wptr_next;
  logic [AW-1:0] w_b_cptr_next;
  logic [AW-1:0] w_used_next;

  // Acceptance, next-pointer selection (drop / commit) and next occupancy.
  always_comb begin
    w_drop_eff    = 1'b0;
    w_acc         = 1'b0;
    w_ovf_att     = 1'b0;
    w_wptr_inc    = ZERO;
    w_b_wptr_next = r_b_wptr;
    w_b_cptr_next = r_b_cptr;
    w_used_next   = ZERO;

    w_drop_eff = PKT & w_drop;
    w_acc      = w_en & ~r_full & ~w_drop_eff;
    w_ovf_att  = w_en &  r_full & ~w_drop_eff;
    w_wptr_inc = r_b_wptr + ONE;

    // A drop rewinds to the commit point; it also forces w_acc low.
    if (w_drop_eff) begin
      w_b_wptr_next = r_b_cptr;
    end else if (w_acc) begin
      w_b_wptr_next = w_wptr_inc;
    end else begin
      w_b_wptr_next = r_b_wptr;
    end

    if (PKT) begin
      if (w_acc && w_last) begin
        w_b_cptr_next = w_wptr_inc;
      end else begin
        w_b_cptr_next = r_b_cptr;
      end
    end else begin
      w_b_cptr_next = w_b_wptr_next;
    end

    // Uncommitted words still occupy RAM, so count from the write pointer.
    w_used_next = w_b_wptr_next - r_b_rptr_sync;
  end

  // Read-pointer synchroniser chain, followed by a registered gray-to-binary stage.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= ZERO;
      end
      r_b_rptr_sync <= ZERO;
    end else begin
      r_sync[0] <= g_rptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_b_rptr_sync <= gray2bin(r_sync[SYNC_STAGES-1]);
    end
  end

  // Pointers, published gray pointer and status registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_b_wptr      <= ZERO;
      r_b_cptr      <= ZERO;
      r_g_wptr      <= ZERO;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_usedw       <= ZERO;
    end else begin
      r_b_wptr      <= w_b_wptr_next;
      r_b_cptr      <= w_b_cptr_next;
      r_g_wptr      <= bin2gray(w_b_cptr_next);
      r_full        <= (w_used_next == DEPTH);
      r_almost_full <= (w_used_next >= afull_thr);
      r_usedw       <= w_used_next;
    end
  end

  // Sticky overflow flag; a new attempt wins over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_att) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign wr_ok       = w_acc;
  assign waddr       = r_b_wptr[PTR_WIDTH-1:0];
  assign g_wptr      = r_g_wptr;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign usedw       = r_usedw;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_wptr_ctrl.sv
// tb_wptr_ctrl: directed bench driving a stream-mode instance (s_*) and a
// packet-mode instance (p_*). The two instances share the clock and the reset.
module tb_wptr_ctrl;

  logic wclk;
  logic wrst_n;

  logic       s_w_en, s_w_last, s_w_drop, s_ovf_clr;
  logic [4:0] s_rptr, s_thr;
  logic       s_wr_ok, s_full, s_afull, s_ovf;
  logic [3:0] s_waddr;
  logic [4:0] s_g_wptr, s_usedw;

  logic       p_w_en, p_w_last, p_w_drop, p_ovf_clr;
  logic [4:0] p_rptr, p_thr;
  logic       p_wr_ok, p_full, p_afull, p_ovf;
  logic [3:0] p_waddr;
  logic [4:0] p_g_wptr, p_usedw;

  int n_pass  = 0;
  int n_total = 0;

  wptr_ctrl #(.PTR_WIDTH(4), .SYNC_STAGES(2), .PKT_MODE(0)) dut_s (
    .wclk(wclk), .wrst_n(wrst_n), .w_en(s_w_en), .w_last(s_w_last), .w_drop(s_w_drop),
    .g_rptr_async(s_rptr), .afull_thr(s_thr), .ovf_clr(s_ovf_clr),
    .wr_ok(s_wr_ok), .waddr(s_waddr), .g_wptr(s_g_wptr), .full(s_full),
    .almost_full(s_afull), .usedw(s_usedw), .overflow(s_ovf)
  );

  wptr_ctrl #(.PTR_WIDTH(4), .SYNC_STAGES(2), .PKT_MODE(1)) dut_p (
    .wclk(wclk), .wrst_n(wrst_n), .w_en(p_w_en), .w_last(p_w_last), .w_drop(p_w_drop),
    .g_rptr_async(p_rptr), .afull_thr(p_thr), .ovf_clr(p_ovf_clr),
    .wr_ok(p_wr_ok), .waddr(p_waddr), .g_wptr(p_g_wptr), .full(p_full),
    .almost_full(p_afull), .usedw(p_usedw), .overflow(p_ovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if ({s_wr_ok, s_waddr, s_g_wptr, s_full, s_afull, s_usedw, s_ovf} !== 18'd0)
      $display("FAIL rst_stream outs=%h want 0", {s_wr_ok, s_waddr, s_g_wptr, s_full, s_afull, s_usedw, s_ovf}); else n_pass++;
    n_total++; if ({p_wr_ok, p_waddr, p_g_wptr, p_full, p_afull, p_usedw, p_ovf} !== 18'd0)
      $display("FAIL rst_pkt outs=%h want 0", {p_wr_ok, p_waddr, p_g_wptr, p_full, p_afull, p_usedw, p_ovf}); else n_pass++;
    #4 wrst_n = 1'b1;
    tick();
    n_total++; if (p_afull !== 1'b1) $display("FAIL afull_thr0 got=%b want=1", p_afull); else n_pass++;
    n_total++; if (s_afull !== 1'b0) $display("FAIL afull_thr12_idle got=%b want=0", s_afull); else n_pass++;
  endtask

  task automatic test_stream_fill();
    for (int i = 0; i < 16; i++) begin
      s_w_en = 1'b1;
      #1;
      n_total++; if (s_wr_ok !== 1'b1) $display("FAIL fill_wr_ok[%0d] got=%b want=1", i, s_wr_ok); else n_pass++;
      n_total++; if (s_waddr !== 4'(i)) $display("FAIL fill_waddr[%0d] got=%0d want=%0d", i, s_waddr, i); else n_pass++;
      tick();
      n_total++; if (s_usedw !== 5'(i + 1)) $display("FAIL fill_usedw[%0d] got=%0d want=%0d", i, s_usedw, i + 1); else n_pass++;
      n_total++; if (s_full !== (i == 15)) $display("FAIL fill_full[%0d] got=%b want=%b", i, s_full, (i == 15)); else n_pass++;
      n_total++; if (s_afull !== (i + 1 >= 12)) $display("FAIL fill_afull[%0d] got=%b want=%b", i, s_afull, (i + 1 >= 12)); else n_pass++;
      n_total++; if (s_g_wptr !== gray5(i + 1)) $display("FAIL fill_gwptr[%0d] got=%b want=%b", i, s_g_wptr, gray5(i + 1)); else n_pass++;
    end
    n_total++; if (s_g_wptr !== 5'b11000) $display("FAIL fill_gwptr_final got=%b want=11000", s_g_wptr); else n_pass++;
  endtask

  task automatic test_overflow();
    s_w_en = 1'b1;
    #1;
    n_total++; if (s_wr_ok !== 1'b0) $display("FAIL ovf_wr_ok got=%b want=0", s_wr_ok); else n_pass++;
    tick();
    n_total++; if (s_ovf !== 1'b1) $display("FAIL ovf_set got=%b want=1", s_ovf); else n_pass++;
    n_total++; if (s_waddr !== 4'd0 || s_usedw !== 5'd16) $display("FAIL ovf_ptr_hold waddr=%0d usedw=%0d want 0/16", s_waddr, s_usedw); else n_pass++;
    s_ovf_clr = 1'b1;
    tick();
    n_total++; if (s_ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b want=1", s_ovf); else n_pass++;
    s_w_en = 1'b0;
    tick();
    n_total++; if (s_ovf !== 1'b0) $display("FAIL ovf_clear got=%b want=0", s_ovf); else n_pass++;
    s_ovf_clr = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 1; k <= 33; k++) begin
      s_rptr = gray5(k);
      s_w_en = 1'b0;
      for (int t = 1; t <= 3; t++) begin
        tick();
        n_total++; if (s_full !== 1'b1) $display("FAIL wrap_full_held[%0d.%0d] got=%b want=1", k, t, s_full); else n_pass++;
      end
      tick();
      n_total++; if (s_full !== 1'b0 || s_usedw !== 5'd15)
        $display("FAIL wrap_free[%0d] full=%b usedw=%0d want 0/15", k, s_full, s_usedw); else n_pass++;
      s_w_en = 1'b1;
      #1;
      n_total++; if (s_wr_ok !== 1'b1 || s_waddr !== 4'(15 + k))
        $display("FAIL wrap_wr[%0d] wr_ok=%b waddr=%0d want 1/%0d", k, s_wr_ok, s_waddr, (15 + k) % 16); else n_pass++;
      tick();
      n_total++; if (s_full !== 1'b1 || s_usedw !== 5'd16 || s_g_wptr !== gray5(16 + k))
        $display("FAIL wrap_after[%0d] full=%b usedw=%0d g=%b want 1/16/%b", k, s_full, s_usedw, s_g_wptr, gray5(16 + k)); else n_pass++;
      s_w_en = 1'b0;
    end
  endtask

  task automatic test_pkt_commit();
    for (int i = 0; i < 5; i++) begin
      p_w_en   = 1'b1;
      p_w_last = (i == 4);
      tick();
      n_total++; if (p_g_wptr !== ((i == 4) ? 5'b00111 : 5'b00000))
        $display("FAIL commit_gwptr[%0d] got=%b want=%b", i, p_g_wptr, ((i == 4) ? 5'b00111 : 5'b00000)); else n_pass++;
      n_total++; if (p_usedw !== 5'(i + 1)) $display("FAIL commit_usedw[%0d] got=%0d want=%0d", i, p_usedw, i + 1); else n_pass++;
    end
    p_w_en   = 1'b0;
    p_w_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_w_en = 1'b1;
    tick();
    n_total++; if (s_ovf !== 1'b1) $display("FAIL mid_pre_ovf got=%b want=1", s_ovf); else n_pass++;
    #3 wrst_n = 1'b0;
    s_rptr = 5'd0;
    #1;
    n_total++; if ({s_waddr, s_g_wptr, s_full, s_afull, s_usedw, s_ovf} !== 17'd0)
      $display("FAIL mid_rst_stream outs=%h want 0", {s_waddr, s_g_wptr, s_full, s_afull, s_usedw, s_ovf}); else n_pass++;
    n_total++; if ({p_waddr, p_g_wptr, p_full, p_usedw, p_ovf} !== 16'd0)
      $display("FAIL mid_rst_pkt outs=%h want 0", {p_waddr, p_g_wptr, p_full, p_usedw, p_ovf}); else n_pass++;
    #1 wrst_n = 1'b1;
    #1;
    n_total++; if (s_wr_ok !== 1'b1 || s_waddr !== 4'd0) $display("FAIL mid_first_wr wr_ok=%b waddr=%0d want 1/0", s_wr_ok, s_waddr); else n_pass++;
    tick();
    n_total++; if (s_usedw !== 5'd1 || s_waddr !== 4'd1 || s_g_wptr !== 5'b00001)
      $display("FAIL mid_after_wr usedw=%0d waddr=%0d g=%b want 1/1/00001", s_usedw, s_waddr, s_g_wptr); else n_pass++;
    s_w_en = 1'b0;
  endtask

  task automatic test_pkt_drop();
    for (int i = 0; i < 7; i++) begin
      p_w_en   = 1'b1;
      p_w_last = (i == 2);
      tick();
      n_total++; if (p_g_wptr !== ((i >= 2) ? 5'b00010 : 5'b00000))
        $display("FAIL drop_gwptr[%0d] got=%b want=%b", i, p_g_wptr, ((i >= 2) ? 5'b00010 : 5'b00000)); else n_pass++;
      n_total++; if (p_usedw !== 5'(i + 1)) $display("FAIL drop_usedw[%0d] got=%0d want=%0d", i, p_usedw, i + 1); else n_pass++;
    end
    p_w_last = 1'b0;
    p_w_drop = 1'b1;
    #1;
    n_total++; if (p_wr_ok !== 1'b0) $display("FAIL drop_wr_ok got=%b want=0", p_wr_ok); else n_pass++;
    tick();
    n_total++; if (p_usedw !== 5'd3 || p_waddr !== 4'd3 || p_g_wptr !== 5'b00010 || p_ovf !== 1'b0)
      $display("FAIL drop_rewind usedw=%0d waddr=%0d g=%b ovf=%b want 3/3/00010/0", p_usedw, p_waddr, p_g_wptr, p_ovf); else n_pass++;
    p_w_drop = 1'b0;
    p_w_last = 1'b1;
    #1;
    n_total++; if (p_wr_ok !== 1'b1 || p_waddr !== 4'd3) $display("FAIL drop_next_wr wr_ok=%b waddr=%0d want 1/3", p_wr_ok, p_waddr); else n_pass++;
    tick();
    n_total++; if (p_g_wptr !== 5'b00110 || p_usedw !== 5'd4)
      $display("FAIL drop_recommit g=%b usedw=%0d want 00110/4", p_g_wptr, p_usedw); else n_pass++;
    p_w_en   = 1'b0;
    p_w_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n = 1'b0;
    s_w_en = 1'b0; s_w_last = 1'b0; s_w_drop = 1'b0; s_ovf_clr = 1'b0; s_rptr = 5'd0; s_thr = 5'd12;
    p_w_en = 1'b0; p_w_last = 1'b0; p_w_drop = 1'b0; p_ovf_clr = 1'b0; p_rptr = 5'd0; p_thr = 5'd0;
    test_reset();
    test_stream_fill();
    test_overflow();
    test_wrap();
    test_pkt_commit();
    test_reset_mid();
    test_pkt_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
